// File: rtl/add_cla_pipe_pkg.sv
// Shared constants and helpers for the pipelined look-ahead adder.
// Optional feature macro: ADD_CLA_OVF_EN (signed overflow output).
package add_cla_pipe_pkg;

  localparam int unsigned GROUP_W = 4;

  function automatic int unsigned stage_count(input int unsigned width);
    return width / GROUP_W;
  endfunction

  function automatic bit width_ok(input int unsigned width);
    return ((width % GROUP_W) == 0) && (width >= GROUP_W) && (width <= 64);
  endfunction

endpackage

// File: rtl/add_cla_pipe_if.sv
// Operand/result valid-ready bus of add_cla_pipe.
// Optional feature macro: ADD_CLA_OVF_EN adds the ov signal.
interface add_cla_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
`ifdef ADD_CLA_OVF_EN
  logic             ov;

  modport master (output in_valid, a, b, ci, sub, out_ready,
                  input  in_ready, out_valid, s, co, ov);
  modport slave  (input  in_valid, a, b, ci, sub, out_ready,
                  output in_ready, out_valid, s, co, ov);
`else
  modport master (output in_valid, a, b, ci, sub, out_ready,
                  input  in_ready, out_valid, s, co);
  modport slave  (input  in_valid, a, b, ci, sub, out_ready,
                  output in_ready, out_valid, s, co);
`endif
endinterface

// File: rtl/add_cla_pipe_cla4_slice.sv
// Combinational 4-bit carry look-ahead group built from NAND/NOT terms.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       p,
  output logic       g,
  output logic       c3
);
  logic [3:0] gn, gi, pi, xa, xb;
  logic       c1, c2;
  logic       p10, p21, p32, p321;

  // Bit generate (NAND) and propagate (four-NAND XOR sharing gn)
  assign gn = ~(a & b);
  assign gi = ~gn;
  assign xa = ~(a & gn);
  assign xb = ~(b & gn);
  assign pi = ~(xa & xb);

  assign p10  = pi[1] & pi[0];
  assign p21  = pi[2] & pi[1];
  assign p32  = pi[3] & pi[2];
  assign p321 = p32 & pi[1];

  assign c1 = ~(gn[0] & ~(pi[0] & cin));
  assign c2 = ~(gn[1] & ~(pi[1] & gi[0]) & ~(p10 & cin));
  assign c3 = ~(gn[2] & ~(pi[2] & gi[1]) & ~(p21 & gi[0]) & ~(p21 & pi[0] & cin));

  assign p    = p321 & pi[0];
  assign g    = ~(gn[3] & ~(pi[3] & gi[2]) & ~(p32 & gi[1]) & ~(p321 & gi[0]));
  assign cout = ~(~g & ~(p & cin));

  assign s = pi ^ {c3, c2, c1, cin};
endmodule

// File: rtl/add_cla_pipe.sv
// Pipelined WIDTH-bit add/sub: one 4-bit look-ahead group resolved per stage.
// Optional feature macro: ADD_CLA_OVF_EN registers signed overflow on bus.ov.
module add_cla_pipe
  import add_cla_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  add_cla_pipe_if.slave  bus
);
  localparam int unsigned STAGES = stage_count(WIDTH);

  if (!width_ok(WIDTH)) begin : g_width_chk
    $error("add_cla_pipe: WIDTH must be a multiple of 4 in 4..64");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             ci_eff;

  // Global advance: every stage moves together, bubbles included
  assign adv          = ~g_stg[STAGES-1].vld_q | bus.out_ready;
  assign bus.in_ready = adv;
  assign b_eff        = bus.sub ? ~bus.b : bus.b;
  assign ci_eff       = bus.ci | bus.sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic             vld_q, cry_q;
    logic [WIDTH-1:0] acc_q;   // finished sum bits below, unconsumed A bits above
    logic [WIDTH-1:0] b_q;     // effective B shifted so the next group sits in [3:0]
    logic             v_src, c_src;
    logic [WIDTH-1:0] acc_src, b_src, acc_d;
    logic [3:0]       ss;
    logic             scout, sp, sg, sc3;

    if (k == 0) begin : g_src
      assign v_src   = bus.in_valid;
      assign acc_src = bus.a;
      assign b_src   = b_eff;
      assign c_src   = ci_eff;
    end else begin : g_src
      assign v_src   = g_stg[k-1].vld_q;
      assign acc_src = g_stg[k-1].acc_q;
      assign b_src   = g_stg[k-1].b_q;
      assign c_src   = g_stg[k-1].cry_q;
    end

    cla4_slice u_slice (
      .a    (acc_src[GROUP_W*k +: GROUP_W]),
      .b    (b_src[GROUP_W-1:0]),
      .cin  (c_src),
      .s    (ss),
      .cout (scout),
      .p    (sp),
      .g    (sg),
      .c3   (sc3)
    );

    always_comb begin
      acc_d = acc_src;
      acc_d[GROUP_W*k +: GROUP_W] = ss;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        acc_q <= '0;
        b_q   <= '0;
        cry_q <= 1'b0;
      end else if (adv) begin
        vld_q <= v_src;
        acc_q <= acc_d;
        b_q   <= b_src >> GROUP_W;
        cry_q <= scout;
      end
    end

`ifdef ADD_CLA_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ov_q;
      // Carry into the MSB versus carry out of it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ov_q <= 1'b0;
        else if (adv) ov_q <= sc3 ^ scout;
      end
    end
`endif
  end

  assign bus.out_valid = g_stg[STAGES-1].vld_q;
  assign bus.s         = g_stg[STAGES-1].acc_q;
  assign bus.co        = g_stg[STAGES-1].cry_q;
`ifdef ADD_CLA_OVF_EN
  assign bus.ov        = g_stg[STAGES-1].g_ovf.ov_q;
`endif
endmodule
